// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between program_counter and decode, with redirect handling.
// Latency: imem_req to inst_valid is 1 cycle plus memory wait cycles; best case one instruction every 2 cycles.
// Backpressure: while inst_ready is low the fetched word is held and the PC is frozen (pc_in = pc_out).
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   pc_out / pc_in             current PC in, next PC out (combinational) to program_counter
//   imem_req/addr/ack/rdata    instruction memory req/ack handshake; addr is registered
//   inst_valid/inst/inst_pc    fetched word to decode, handed off on inst_ready
//   redirect_valid/target      taken branch/jump from execute
//   misalign_fault             single-cycle flag for a rejected (misaligned) redirect
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_out,
    output logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    logic        redirect_ok;   // aligned redirect that takes effect this cycle
    logic        redirect_bad;  // misaligned redirect that is rejected this cycle
    logic [31:0] pc_inc;
    logic [31:0] pc_next;

    // Sequential successor; 32-bit wrap is intentional (FFFFFFFC -> 00000000).
    assign pc_inc = pc_out + 32'd4;

    // Redirects are only meaningful once fetching has started; IDLE ignores them.
    always_comb begin
        redirect_ok  = 1'b0;
        redirect_bad = 1'b0;
        if (state != IDLE && redirect_valid) begin
            redirect_ok  = (redirect_target[1:0] == 2'b00);
            redirect_bad = (redirect_target[1:0] != 2'b00);
        end
    end

    // Next-PC selection. program_counter has no enable, so "hold" is pc_out.
    // The same value is what imem_addr loads on every transition into REQ,
    // which keeps the PC register and the request address in lockstep.
    always_comb begin
        pc_next = pc_out;
        if (state == IDLE) begin
            pc_next = RESET_VECTOR;
        end else if (redirect_ok) begin
            pc_next = redirect_target;
        end else if (state == HOLD && inst_ready) begin
            pc_next = pc_inc;
        end
    end

    assign pc_in          = reset ? pc_next : RESET_VECTOR;
    assign misalign_fault = reset & redirect_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_VECTOR;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    imem_addr <= RESET_VECTOR;
                    imem_req  <= 1'b1;
                    state     <= REQ;
                end

                REQ: begin
                    if (imem_ack) begin
                        if (redirect_ok) begin
                            // Returned word belongs to the wrong path: drop it and
                            // re-request at the target without leaving REQ.
                            imem_addr <= pc_next;
                        end else begin
                            inst       <= imem_rdata;
                            inst_pc    <= imem_addr;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (redirect_ok) begin
                        // The memory still owns the old request; keep req/addr
                        // stable and swallow its response in DISCARD.
                        state <= DISCARD;
                    end
                end

                HOLD: begin
                    // Redirect and handoff both leave HOLD the same way; the
                    // only difference is the PC, already resolved in pc_next.
                    if (redirect_ok || inst_ready) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        imem_addr  <= pc_next;
                        imem_req   <= 1'b1;
                        state      <= REQ;
                    end
                end

                DISCARD: begin
                    // pc_next already reflects the most recent redirect, including
                    // one arriving in the same cycle as the stale ack.
                    if (imem_ack) begin
                        imem_addr <= pc_next;
                        state     <= REQ;
                    end
                end

                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
